to_serial: RTL and testbench

- Serializer stage that sits directly upstream of from_serial on the narrow inter-stage link.
- Accepts one NO_CH-channel word of BW_IN bits per channel via a valid/ready handshake.
- Emits each word as NO_CYC = BW_IN/BW_OUT consecutive BW_OUT-bit slices per channel, least significant slice first. This is the order from_serial reassembles, so the pair round-trips losslessly.
- A one-word pending buffer lets a new word be accepted while the current word is shifting out, giving gapless back-to-back output.

---
 rtl/to_serial_if.sv | 32 +++
 rtl/to_serial.sv | 98 +++++++++
 tb/tb_to_serial.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/to_serial_if.sv
// Handshake bundle for the to_serial stage: wide word in on one side, narrow slices out on the other.
// The master modport is the environment driving the block; slave is the block itself.
interface to_serial_if #(
    parameter int NO_CH  = 10,
    parameter int BW_IN  = 8,
    parameter int BW_OUT = 2
);
    logic                           vld_in;
    logic                           rdy_out;
    logic [NO_CH-1:0][BW_IN-1:0]    data_in;
    logic                           vld_out;
    logic                           rdy_in;
    logic [NO_CH-1:0][BW_OUT-1:0]   data_out;

    modport master (
        output vld_in,
        output data_in,
        output rdy_in,
        input  rdy_out,
        input  vld_out,
        input  data_out
    );

    modport slave (
        input  vld_in,
        input  data_in,
        input  rdy_in,
        output rdy_out,
        output vld_out,
        output data_out
    );
endinterface

// File: rtl/to_serial.sv
// Serializer: accepts one multi-channel wide word and emits it as BW_IN/BW_OUT narrow slices per
// channel, least significant slice first, with a one-word pending buffer for gapless streaming.
module to_serial #(
    parameter int NO_CH  = 10,
    parameter int BW_IN  = 8,
    parameter int BW_OUT = 2
) (
    input  logic        clk,
    input  logic        rst,
    to_serial_if.slave  bus
);
    localparam int NO_CYC = BW_IN / BW_OUT;
    localparam int CW     = (NO_CYC > 1) ? $clog2(NO_CYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NO_CYC - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                         r_state;
    logic                           r_vld_out;
    logic [CW-1:0]                  r_cnt;
    logic [NO_CH-1:0][BW_IN-1:0]    r_shift;
    logic [NO_CH-1:0][BW_IN-1:0]    r_pend;
    logic                           r_pend_vld;

    logic                           w_accept;
    logic                           w_fire;
    logic                           w_last;

    // Ready depends only on the pending flag, so no combinational path from vld_in or rdy_in.
    assign bus.rdy_out = !r_pend_vld && !rst;
    assign bus.vld_out = r_vld_out;

    assign w_accept = bus.vld_in && bus.rdy_out;
    assign w_fire   = r_vld_out && bus.rdy_in;
    assign w_last   = (r_cnt == LAST_CNT);

    always_comb begin
        bus.data_out = '0;
        for (int i = 0; i < NO_CH; i++) begin
            bus.data_out[i] = r_shift[i][BW_OUT-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_vld_out  <= 1'b0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift   <= bus.data_in;
                        r_cnt     <= '0;
                        r_state   <= SHIFT;
                        r_vld_out <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (w_fire && w_last) begin
                        // Pending word wins; a same-cycle accept can only happen when nothing is pending.
                        if (r_pend_vld) begin
                            r_shift    <= r_pend;
                            r_cnt      <= '0;
                            r_pend_vld <= 1'b0;
                        end else if (w_accept) begin
                            r_shift <= bus.data_in;
                            r_cnt   <= '0;
                        end else begin
                            r_state   <= IDLE;
                            r_vld_out <= 1'b0;
                        end
                    end else begin
                        if (w_fire) begin
                            for (int i = 0; i < NO_CH; i++) begin
                                r_shift[i] <= r_shift[i] >> BW_OUT;
                            end
                            r_cnt <= r_cnt + CW'(1);
                        end
                        if (w_accept) begin
                            r_pend     <= bus.data_in;
                            r_pend_vld <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_vld_out <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_to_serial.sv
// Self-checking bench for to_serial: a 4-slice instance checked through a slice scoreboard,
// plus a single-slice instance exercised as a registered pass-through with skid buffer.
module tb_to_serial;
    localparam int NO_CH  = 2;
    localparam int BW_IN  = 8;
    localparam int BW_OUT = 2;
    localparam int NO_CYC = BW_IN / BW_OUT;

    logic clk;
    logic rst;

    int checkCount;
    int errorCount;

    logic [NO_CH*BW_OUT-1:0] expQ[$];

    to_serial_if #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_OUT(BW_OUT)) bus ();
    to_serial_if #(.NO_CH(NO_CH), .BW_IN(8), .BW_OUT(8))          bus1 ();

    to_serial #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_OUT(BW_OUT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    to_serial #(.NO_CH(NO_CH), .BW_IN(8), .BW_OUT(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Expected slices are cut straight from the accepted word, lowest slice first.
    task automatic pushWord(input logic [NO_CH-1:0][BW_IN-1:0] word);
        logic [NO_CH*BW_OUT-1:0] slice;
        for (int c = 0; c < NO_CYC; c++) begin
            slice = '0;
            for (int ch = 0; ch < NO_CH; ch++) begin
                slice[ch*BW_OUT +: BW_OUT] = word[ch][c*BW_OUT +: BW_OUT];
            end
            expQ.push_back(slice);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vld, input logic [NO_CH-1:0][BW_IN-1:0] word, input logic rdy);
        bus.vld_in  = vld;
        bus.data_in = word;
        bus.rdy_in  = rdy;
    endtask

    // Scoreboard sampled mid-cycle: what is seen here is what the next rising edge transfers.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
        end else begin
            if (bus.vld_out && bus.rdy_in) begin
                if (expQ.size() == 0)
                    checkOutput("stale_slice", 32'(bus.vld_out), 32'd0);
                else
                    checkOutput("slice", 32'(bus.data_out), 32'(expQ.pop_front()));
            end
            if (bus.vld_in && bus.rdy_out)
                pushWord(bus.data_in);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int budget;
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b1);
        bus1.vld_in  = 1'b0;
        bus1.data_in = '0;
        bus1.rdy_in  = 1'b1;

        // Reset state
        repeat (3) stepCycle();
        checkOutput("rst_vld_out", 32'(bus.vld_out), 32'd0);
        checkOutput("rst_data_out", 32'(bus.data_out), 32'd0);
        checkOutput("rst_rdy_out", 32'(bus.rdy_out), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_rdy", 32'(bus.rdy_out), 32'd1);
        stepCycle();

        // Single word with rdy_in held high
        applyStimulus(1'b1, {8'h1E, 8'hB4}, 1'b1);
        checkOutput("single_rdy_pre", 32'(bus.rdy_out), 32'd1);
        stepCycle();
        bus.vld_in = 1'b0;
        for (int k = 0; k < NO_CYC; k++) begin
            checkOutput("single_vld", 32'(bus.vld_out), 32'd1);
            checkOutput("single_rdy", 32'(bus.rdy_out), 32'd1);
            stepCycle();
        end
        checkOutput("single_end_vld", 32'(bus.vld_out), 32'd0);
        checkOutput("single_end_q", 32'(expQ.size()), 32'd0);
        stepCycle();

        // Back-to-back words with vld_in held high
        applyStimulus(1'b1, {8'h1E, 8'hB4}, 1'b1);
        stepCycle();
        for (int k = 0; k < 3 * NO_CYC; k++) begin
            checkOutput("b2b_vld", 32'(bus.vld_out), 32'd1);
            case (k)
                0: begin
                    checkOutput("b2b_rdy0", 32'(bus.rdy_out), 32'd1);
                    bus.data_in = {8'h00, 8'hFF};
                end
                1: begin
                    checkOutput("b2b_rdy_pend", 32'(bus.rdy_out), 32'd0);
                    bus.data_in = {8'h5A, 8'hC3};
                end
                2, 3: checkOutput("b2b_rdy_hold", 32'(bus.rdy_out), 32'd0);
                4: checkOutput("b2b_rdy_reopen", 32'(bus.rdy_out), 32'd1);
                5: begin
                    checkOutput("b2b_rdy_third", 32'(bus.rdy_out), 32'd0);
                    bus.vld_in = 1'b0;
                end
                default: ;
            endcase
            stepCycle();
        end
        checkOutput("b2b_end_vld", 32'(bus.vld_out), 32'd0);
        checkOutput("b2b_end_q", 32'(expQ.size()), 32'd0);
        stepCycle();

        // Backpressure after the second slice
        applyStimulus(1'b1, {8'h1E, 8'hB4}, 1'b1);
        stepCycle();
        bus.vld_in = 1'b0;
        stepCycle();
        bus.rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput("bp_vld", 32'(bus.vld_out), 32'd1);
            checkOutput("bp_data", 32'(bus.data_out), 32'h0000_000D);
        end
        bus.rdy_in = 1'b1;
        repeat (3) stepCycle();
        checkOutput("bp_end_vld", 32'(bus.vld_out), 32'd0);
        checkOutput("bp_end_q", 32'(expQ.size()), 32'd0);
        stepCycle();

        // Reset mid-word with a second word pending
        applyStimulus(1'b1, {8'h1E, 8'hB4}, 1'b1);
        stepCycle();
        bus.data_in = {8'h00, 8'hFF};
        stepCycle();
        bus.vld_in = 1'b0;
        stepCycle();
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_rdy_comb", 32'(bus.rdy_out), 32'd0);
        stepCycle();
        checkOutput("mid_rst_vld", 32'(bus.vld_out), 32'd0);
        checkOutput("mid_rst_data", 32'(bus.data_out), 32'd0);
        checkOutput("mid_rst_rdy", 32'(bus.rdy_out), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_release_rdy", 32'(bus.rdy_out), 32'd1);
        for (int k = 0; k < 6; k++) begin
            stepCycle();
            checkOutput("mid_rst_quiet", 32'(bus.vld_out), 32'd0);
        end

        // Random traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, (NO_CH*BW_IN)'($urandom), $urandom_range(0, 3) != 0);
            stepCycle();
        end
        applyStimulus(1'b0, '0, 1'b1);
        budget = 0;
        while ((expQ.size() != 0 || bus.vld_out) && budget < 100) begin
            stepCycle();
            budget++;
        end
        checkOutput("rand_drain_q", 32'(expQ.size()), 32'd0);
        checkOutput("rand_drain_vld", 32'(bus.vld_out), 32'd0);

        // Single-slice instance: one-cycle latency
        bus1.rdy_in  = 1'b1;
        bus1.vld_in  = 1'b1;
        bus1.data_in = {8'hA5, 8'h3C};
        stepCycle();
        bus1.vld_in = 1'b0;
        checkOutput("p1_vld", 32'(bus1.vld_out), 32'd1);
        checkOutput("p1_data", 32'(bus1.data_out), 32'h0000_A53C);
        stepCycle();
        checkOutput("p1_idle", 32'(bus1.vld_out), 32'd0);

        // Single-slice instance: skid buffer under backpressure
        bus1.rdy_in  = 1'b0;
        bus1.vld_in  = 1'b1;
        bus1.data_in = {8'h11, 8'h22};
        stepCycle();
        checkOutput("skid_first_vld", 32'(bus1.vld_out), 32'd1);
        checkOutput("skid_first_rdy", 32'(bus1.rdy_out), 32'd1);
        bus1.data_in = {8'h33, 8'h44};
        stepCycle();
        checkOutput("skid_pend_rdy", 32'(bus1.rdy_out), 32'd0);
        bus1.data_in = {8'h55, 8'h66};
        stepCycle();
        checkOutput("skid_full_rdy", 32'(bus1.rdy_out), 32'd0);
        checkOutput("skid_hold_data", 32'(bus1.data_out), 32'h0000_1122);
        bus1.vld_in = 1'b0;
        bus1.rdy_in = 1'b1;
        stepCycle();
        checkOutput("skid_second_vld", 32'(bus1.vld_out), 32'd1);
        checkOutput("skid_second_data", 32'(bus1.data_out), 32'h0000_3344);
        stepCycle();
        checkOutput("skid_end_vld", 32'(bus1.vld_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
